// File: rtl/pipe_stage_reg.sv
// Y86 inter-stage pipeline register with stall/bubble control, saturating
// stall/bubble performance counters and a sticky stall+bubble conflict flag.
module pipe_stage_reg #(
  parameter int WORD_W = 32,
  parameter int N_VALS = 4,
  parameter int CODE_W = 4,
  parameter int REG_W  = 4,
  parameter int STAT_W = 3,
  parameter logic [CODE_W-1:0] NOP_ICODE = 4'h1,
  parameter logic [REG_W-1:0]  RNONE     = 4'hF,
  parameter logic [STAT_W-1:0] STAT_AOK  = 3'd1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     bubble_i,
  input  logic                     cnt_clr_i,
  input  logic [CODE_W-1:0]        in_icode,
  input  logic [CODE_W-1:0]        in_ifun,
  input  logic [STAT_W-1:0]        in_stat,
  input  logic [N_VALS*WORD_W-1:0] in_vals,
  input  logic [REG_W-1:0]         in_dstE,
  input  logic [REG_W-1:0]         in_dstM,
  output logic [CODE_W-1:0]        out_icode,
  output logic [CODE_W-1:0]        out_ifun,
  output logic [STAT_W-1:0]        out_stat,
  output logic [N_VALS*WORD_W-1:0] out_vals,
  output logic [REG_W-1:0]         out_dstE,
  output logic [REG_W-1:0]         out_dstM,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic                     conflict_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CODE_W-1:0]        icode_q, icode_d;
  logic [CODE_W-1:0]        ifun_q, ifun_d;
  logic [STAT_W-1:0]        stat_q, stat_d;
  logic [N_VALS*WORD_W-1:0] vals_q, vals_d;
  logic [REG_W-1:0]         dstE_q, dstE_d;
  logic [REG_W-1:0]         dstM_q, dstM_d;
  logic                     valid_q, valid_d;
  logic [CNT_W-1:0]         stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]         bubbleCnt_q, bubbleCnt_d;
  logic                     conflict_q, conflict_d;

  // Stall dominates bubble; a bubble clears the payload so no stale data leaks.
  always_comb begin
    icode_d = icode_q;
    ifun_d  = ifun_q;
    stat_d  = stat_q;
    vals_d  = vals_q;
    dstE_d  = dstE_q;
    dstM_d  = dstM_q;
    valid_d = valid_q;
    if (!stall_i) begin
      if (bubble_i) begin
        icode_d = NOP_ICODE;
        ifun_d  = '0;
        stat_d  = STAT_AOK;
        vals_d  = '0;
        dstE_d  = RNONE;
        dstM_d  = RNONE;
        valid_d = 1'b0;
      end else begin
        icode_d = in_icode;
        ifun_d  = in_ifun;
        stat_d  = in_stat;
        vals_d  = in_vals;
        dstE_d  = in_dstE;
        dstM_d  = in_dstM;
        valid_d = 1'b1;
      end
    end
  end

  // Counters saturate at all-ones; a clear overrides any same-cycle increment.
  always_comb begin
    stallCnt_d  = stallCnt_q;
    bubbleCnt_d = bubbleCnt_q;
    if (cnt_clr_i) begin
      stallCnt_d  = '0;
      bubbleCnt_d = '0;
    end else begin
      if (stall_i && (stallCnt_q != CNT_MAX))
        stallCnt_d = stallCnt_q + 1'b1;
      if (bubble_i && !stall_i && (bubbleCnt_q != CNT_MAX))
        bubbleCnt_d = bubbleCnt_q + 1'b1;
    end
    conflict_d = conflict_q | (stall_i & bubble_i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icode_q     <= NOP_ICODE;
      ifun_q      <= '0;
      stat_q      <= STAT_AOK;
      vals_q      <= '0;
      dstE_q      <= RNONE;
      dstM_q      <= RNONE;
      valid_q     <= 1'b0;
      stallCnt_q  <= '0;
      bubbleCnt_q <= '0;
      conflict_q  <= 1'b0;
    end else begin
      icode_q     <= icode_d;
      ifun_q      <= ifun_d;
      stat_q      <= stat_d;
      vals_q      <= vals_d;
      dstE_q      <= dstE_d;
      dstM_q      <= dstM_d;
      valid_q     <= valid_d;
      stallCnt_q  <= stallCnt_d;
      bubbleCnt_q <= bubbleCnt_d;
      conflict_q  <= conflict_d;
    end
  end

  assign out_icode  = icode_q;
  assign out_ifun   = ifun_q;
  assign out_stat   = stat_q;
  assign out_vals   = vals_q;
  assign out_dstE   = dstE_q;
  assign out_dstM   = dstM_q;
  assign out_valid  = valid_q;
  assign stall_cnt  = stallCnt_q;
  assign bubble_cnt = bubbleCnt_q;
  assign conflict_o = conflict_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized
// stall/bubble/clear traffic compared against a behavioural stage model.
module tb_pipe_stage_reg;

  localparam int WORD_W = 32;
  localparam int N_VALS = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     stall_i, bubble_i, cnt_clr_i;
  logic [3:0]               in_icode, in_ifun, in_dstE, in_dstM;
  logic [2:0]               in_stat;
  logic [N_VALS*WORD_W-1:0] in_vals;
  logic [3:0]               out_icode, out_ifun, out_dstE, out_dstM;
  logic [2:0]               out_stat;
  logic [N_VALS*WORD_W-1:0] out_vals;
  logic                     out_valid, conflict_o;
  logic [CNT_W-1:0]         stall_cnt, bubble_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model of the stage contents
  logic [3:0]               mIcode, mIfun, mDstE, mDstM;
  logic [2:0]               mStat;
  logic [N_VALS*WORD_W-1:0] mVals;
  logic                     mValid, mConflict;
  int                       mStallCnt, mBubbleCnt;

  pipe_stage_reg #(.WORD_W(WORD_W), .N_VALS(N_VALS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .bubble_i(bubble_i), .cnt_clr_i(cnt_clr_i),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_stat(in_stat), .in_vals(in_vals),
    .in_dstE(in_dstE), .in_dstM(in_dstM),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_stat(out_stat), .out_vals(out_vals),
    .out_dstE(out_dstE), .out_dstM(out_dstM), .out_valid(out_valid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .conflict_o(conflict_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mIcode = 4'h1; mIfun = 4'h0; mStat = 3'd1; mVals = '0;
    mDstE = 4'hF; mDstM = 4'hF; mValid = 1'b0;
    mStallCnt = 0; mBubbleCnt = 0; mConflict = 1'b0;
  endtask

  // Applies the stage rules to whatever the inputs were at the clock edge
  task automatic modelClock();
    if (stall_i && bubble_i) mConflict = 1'b1;
    if (stall_i) begin
      if (mStallCnt < CNT_SAT) mStallCnt = mStallCnt + 1;
    end else if (bubble_i) begin
      mIcode = 4'h1; mIfun = 4'h0; mStat = 3'd1; mVals = '0;
      mDstE = 4'hF; mDstM = 4'hF; mValid = 1'b0;
      if (mBubbleCnt < CNT_SAT) mBubbleCnt = mBubbleCnt + 1;
    end else begin
      mIcode = in_icode; mIfun = in_ifun; mStat = in_stat; mVals = in_vals;
      mDstE = in_dstE; mDstM = in_dstM; mValid = 1'b1;
    end
    if (cnt_clr_i) begin
      mStallCnt = 0;
      mBubbleCnt = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".icode"}, 128'(out_icode), 128'(mIcode));
    checkOutput({tag, ".ifun"}, 128'(out_ifun), 128'(mIfun));
    checkOutput({tag, ".stat"}, 128'(out_stat), 128'(mStat));
    checkOutput({tag, ".vals"}, out_vals, mVals);
    checkOutput({tag, ".dstE"}, 128'(out_dstE), 128'(mDstE));
    checkOutput({tag, ".dstM"}, 128'(out_dstM), 128'(mDstM));
    checkOutput({tag, ".valid"}, 128'(out_valid), 128'(mValid));
    checkOutput({tag, ".stallCnt"}, 128'(stall_cnt), 128'(mStallCnt));
    checkOutput({tag, ".bubbleCnt"}, 128'(bubble_cnt), 128'(mBubbleCnt));
    checkOutput({tag, ".conflict"}, 128'(conflict_o), 128'(mConflict));
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic bu, input logic clr,
                               input logic [3:0] icode, input logic [N_VALS*WORD_W-1:0] vals,
                               input logic [3:0] dstE);
    stall_i = st; bubble_i = bu; cnt_clr_i = clr;
    in_icode = icode; in_ifun = icode ^ 4'h5; in_stat = 3'(icode % 4 + 1);
    in_vals = vals; in_dstE = dstE; in_dstM = dstE + 4'h1;
    @(posedge clk);
    modelClock();
    #1;
    checkAll(tag);
  endtask

  logic [N_VALS*WORD_W-1:0] v1234, vDead;

  initial begin
    rst = 1'b0;
    stall_i = 1'b0; bubble_i = 1'b0; cnt_clr_i = 1'b0;
    in_icode = '0; in_ifun = '0; in_stat = '0; in_vals = '0; in_dstE = '0; in_dstM = '0;
    v1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    vDead = {4{32'hDEADBEEF}};
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b1;

    // Stall straight out of reset keeps the reset pattern
    applyStimulus("stallAfterReset", 1, 0, 0, 4'h3, v1234, 4'h2);
    checkOutput("stallAfterReset.validLow", 128'(out_valid), 128'(0));

    for (int i = 0; i < 3; i++)
      applyStimulus("load", 0, 0, 0, 4'h3, v1234, 4'h2);
    checkOutput("load.icode3", 128'(out_icode), 128'(3));

    applyStimulus("load6", 0, 0, 0, 4'h6, v1234, 4'h7);
    applyStimulus("stall1", 1, 0, 0, 4'h5, vDead, 4'h9);
    applyStimulus("stall2", 1, 0, 0, 4'h5, vDead, 4'h9);
    checkOutput("stall.icodeHeld", 128'(out_icode), 128'(6));

    applyStimulus("loadDead", 0, 0, 0, 4'h2, vDead, 4'h3);
    applyStimulus("bubble", 0, 1, 0, 4'h2, vDead, 4'h3);
    checkOutput("bubble.vals", out_vals, 128'(0));
    checkOutput("bubble.cnt", 128'(bubble_cnt), 128'(1));

    applyStimulus("loadPreConflict", 0, 0, 0, 4'h9, v1234, 4'h4);
    applyStimulus("conflict", 1, 1, 0, 4'hA, vDead, 4'h5);
    checkOutput("conflict.flag", 128'(conflict_o), 128'(1));
    applyStimulus("conflictClr", 0, 0, 1, 4'hB, v1234, 4'h6);
    checkOutput("conflict.sticky", 128'(conflict_o), 128'(1));

    for (int i = 0; i < 20; i++)
      applyStimulus("satStall", 1, 0, 0, 4'hC, vDead, 4'h1);
    checkOutput("sat.stallCnt", 128'(stall_cnt), 128'(CNT_SAT));
    applyStimulus("clrWithStall", 1, 0, 1, 4'hC, vDead, 4'h1);
    checkOutput("clr.stallCnt", 128'(stall_cnt), 128'(0));

    // Asynchronous reset between edges while stalling
    stall_i = 1'b1;
    @(posedge clk);
    modelClock();
    #3;
    rst = 1'b0;
    modelReset();
    #1;
    checkAll("asyncReset");
    @(posedge clk);
    #1;
    checkAll("resetHeld");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [3:0] ic, de;
      logic [N_VALS*WORD_W-1:0] rv;
      ic = 4'($urandom);
      de = 4'($urandom);
      rv = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0), ic, rv, de);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
